i2s_dac_out: RTL

- Audio output stage directly downstream of the synthesizer core.
- Takes the parallel left/right sample words (lsound_out/rsound_out) and serializes them to the codec in I2S format.
- Generates the bit clock (AUD_BCLK) and frame clock (AUD_DACLRCK) that drive the synthesizer's trig input.
- Uses a one-deep sample holding register, a per-frame request pulse and underrun accounting.

---
 rtl/holosynth_audio_pkg.sv | 19 +
 rtl/i2s_clkgen.sv | 61 ++++++
 rtl/i2s_dac_out.sv | 99 +++++++++
 3 files changed

// File: rtl/holosynth_audio_pkg.sv
// Shared audio-path constants for the holosynth output stage.
// Default sample/slot/divider sizes and the underrun counter ceiling.
package holosynth_audio_pkg;

    localparam int DEF_AUD_BIT_DEPTH = 24;
    localparam int DEF_SLOT_BITS     = 32;
    localparam int DEF_BCLK_DIV      = 4;

    localparam int FRAME_BITS = 2 * DEF_SLOT_BITS;
    localparam int DIV_W      = $clog2(DEF_BCLK_DIV);
    localparam int POS_W      = $clog2(FRAME_BITS);

    localparam logic [7:0] UNDERRUN_MAX = 8'd255;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == UNDERRUN_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/i2s_clkgen.sv
// I2S bit/frame clock generator: divider, bit position, BCLK and LRCK,
// plus the falling-edge and frame-start strobes used by the serializer.
module i2s_clkgen
    import holosynth_audio_pkg::*;
#(
    parameter int SLOT_BITS = DEF_SLOT_BITS,
    parameter int BCLK_DIV  = DEF_BCLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    output logic bclk,
    output logic lrck,
    output logic fe,
    output logic frame_start
);

    localparam int FB = 2 * SLOT_BITS;
    localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int PW = $clog2(FB);

    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(BCLK_DIV / 2);
    localparam logic [PW-1:0] POS_LAST = PW'(FB - 1);
    localparam logic [PW-1:0] POS_HALF = PW'(SLOT_BITS);

    logic [DW-1:0] div_cnt;
    logic [DW-1:0] div_nxt;
    logic [PW-1:0] bit_pos;
    logic [PW-1:0] pos_nxt;

    // Frame length is a power of two, so bit_pos wraps on its own.
    always_comb begin
        fe          = enable && (div_cnt == DIV_LAST);
        frame_start = fe && (bit_pos == POS_LAST);
        div_nxt     = fe ? '0 : div_cnt + 1'b1;
        pos_nxt     = bit_pos + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            bit_pos <= '0;
            bclk    <= 1'b0;
            lrck    <= 1'b0;
        end else if (!enable) begin
            div_cnt <= '0;
            bit_pos <= '0;
            bclk    <= 1'b0;
            lrck    <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            bclk    <= (div_nxt >= DIV_HALF);
            if (fe) begin
                bit_pos <= pos_nxt;
                lrck    <= (pos_nxt >= POS_HALF);
            end
        end
    end

endmodule

// File: rtl/i2s_dac_out.sv
// I2S DAC output stage: one-deep sample holding register, per-frame latch
// into a shift register, MSB-first serial data and stale-frame counting.
module i2s_dac_out
    import holosynth_audio_pkg::*;
#(
    parameter int AUD_BIT_DEPTH = DEF_AUD_BIT_DEPTH,
    parameter int SLOT_BITS     = DEF_SLOT_BITS,
    parameter int BCLK_DIV      = DEF_BCLK_DIV
) (
    input  logic                     AUDIO_CLK,
    input  logic                     reset_n,
    input  logic                     enable,
    input  logic [AUD_BIT_DEPTH-1:0] lsound_in,
    input  logic [AUD_BIT_DEPTH-1:0] rsound_in,
    input  logic                     sample_valid,
    output logic                     sample_req,
    output logic                     AUD_BCLK,
    output logic                     AUD_DACLRCK,
    output logic                     AUD_DACDAT,
    output logic [7:0]               underrun_cnt
);

    localparam int FB  = 2 * SLOT_BITS;
    localparam int PAD = SLOT_BITS - AUD_BIT_DEPTH;

    logic                     fe;
    logic                     frame_start;
    logic [AUD_BIT_DEPTH-1:0] hold_l;
    logic [AUD_BIT_DEPTH-1:0] hold_r;
    logic [AUD_BIT_DEPTH-1:0] word_l;
    logic [AUD_BIT_DEPTH-1:0] word_r;
    logic [FB-1:0]            frame_word;
    logic [FB-1:0]            shift_reg;
    logic                     fresh;
    logic                     primed;
    logic                     stale;

    i2s_clkgen #(
        .SLOT_BITS (SLOT_BITS),
        .BCLK_DIV  (BCLK_DIV)
    ) u_clkgen (
        .clk         (AUDIO_CLK),
        .rst_n       (reset_n),
        .enable      (enable),
        .bclk        (AUD_BCLK),
        .lrck        (AUD_DACLRCK),
        .fe          (fe),
        .frame_start (frame_start)
    );

    // A strobe coinciding with the latch bypasses straight into the frame.
    always_comb begin
        word_l     = sample_valid ? lsound_in : hold_l;
        word_r     = sample_valid ? rsound_in : hold_r;
        frame_word = {SLOT_BITS'(word_l) << PAD, SLOT_BITS'(word_r) << PAD};
        stale      = !sample_valid && !fresh && primed;
    end

    always_ff @(posedge AUDIO_CLK or negedge reset_n) begin
        if (!reset_n) begin
            hold_l       <= '0;
            hold_r       <= '0;
            shift_reg    <= '0;
            fresh        <= 1'b0;
            primed       <= 1'b0;
            sample_req   <= 1'b0;
            AUD_DACDAT   <= 1'b0;
            underrun_cnt <= '0;
        end else begin
            if (sample_valid) begin
                hold_l <= lsound_in;
                hold_r <= rsound_in;
            end
            if (!enable) begin
                shift_reg  <= '0;
                fresh      <= 1'b0;
                primed     <= 1'b0;
                sample_req <= 1'b0;
                AUD_DACDAT <= 1'b0;
            end else begin
                sample_req <= frame_start;
                if (fe) begin
                    AUD_DACDAT <= shift_reg[FB-1];
                    shift_reg  <= frame_start ? frame_word : shift_reg << 1;
                end
                if (frame_start) begin
                    fresh  <= 1'b0;
                    primed <= 1'b1;
                    if (stale) begin
                        underrun_cnt <= sat_inc(underrun_cnt);
                    end
                end else if (sample_valid) begin
                    fresh <= 1'b1;
                end
            end
        end
    end

endmodule
